// File: rtl/dbg_defs_pkg.sv
// Shared debug-unit definitions: UART command codes and controller state encoding.
package dbg_defs;

    localparam logic [7:0] CMD_RUN       = 8'hF0;
    localparam logic [7:0] CMD_DEBUG     = 8'hFC;
    localparam logic [7:0] CMD_NEXT      = 8'h01;
    localparam logic [7:0] CMD_END_DEBUG = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DBG_IDLE = 3'd2,
        ST_STEP     = 3'd3,
        ST_DUMP     = 3'd4,
        ST_HALTED   = 3'd5
    } dbg_state_e;

    // States in which a command byte may be taken from the RX path.
    function automatic logic accepts_cmd(input dbg_state_e s);
        return (s == ST_IDLE) || (s == ST_DBG_IDLE) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/dbg_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module dbg_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug-unit pipeline sequencer: free-run / single-step gating with state-dump handshake.
// Optional RUN-mode watchdog enabled by defining DBG_TIMEOUT_EN.
module debug_step_ctrl
    import dbg_defs::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          STEP_LEN   = 1,
    parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [7:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt,
    output logic             o_pipe_en,
    output logic             o_dump_req,
    input  logic             i_dump_done,
    output logic             o_halted,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam logic [3:0] STEP_INIT = 4'(STEP_LEN);

    dbg_state_e       state_q, state_d;
    dbg_state_e       ret_q, ret_d;
    logic [3:0]       step_q, step_d;
    logic             ready_q;
    logic             cmd_acc;
    logic             cnt_clr;
    logic             pipe_en;
    logic [CNT_W-1:0] cnt;

`ifdef DBG_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MAX_CYCLES - 32'd1);
    logic timeout_q, timeout_d;
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
`endif

    assign cmd_acc = i_cmd_valid && ready_q;
    assign pipe_en = (state_q == ST_RUN) || (state_q == ST_STEP);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        step_d  = step_q;
        cnt_clr = 1'b0;
`ifdef DBG_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && (i_cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                end else if (cmd_acc && (i_cmd == CMD_DEBUG)) begin
                    state_d = ST_DBG_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_HALTED;
`ifdef DBG_TIMEOUT_EN
                end else if (cnt == TO_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DUMP;
                    ret_d     = ST_HALTED;
`endif
                end
            end
            ST_DBG_IDLE: begin
                if (cmd_acc && (i_cmd == CMD_NEXT)) begin
                    state_d = ST_STEP;
                    step_d  = STEP_INIT;
                end else if (cmd_acc && (i_cmd == CMD_END_DEBUG)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                // A HALT retiring mid-step wins over the normal end of the step.
                if (i_halt) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_HALTED;
                end else if (step_q == 4'd1) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_DBG_IDLE;
                end else begin
                    step_d = step_q - 4'd1;
                end
            end
            ST_DUMP: begin
                if (i_dump_done) begin
                    state_d = ret_q;
                end
            end
            ST_HALTED: begin
                if (cmd_acc && (i_cmd == CMD_END_DEBUG)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state so it reads 0 while reset is held.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            step_q  <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            step_q  <= step_d;
            ready_q <= accepts_cmd(state_d);
        end
    end

`ifdef DBG_TIMEOUT_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    dbg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clr_i   (cnt_clr),
        .en_i    (pipe_en),
        .cnt_o   (cnt)
    );

    assign o_cmd_ready = ready_q;
    assign o_pipe_en   = pipe_en;
    assign o_dump_req  = (state_q == ST_DUMP);
    assign o_halted    = (state_q == ST_HALTED);
    assign o_cycle_cnt = cnt;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Randomized scoreboard bench for debug_step_ctrl: a pipeline model raises i_halt, a TX model answers dumps.
`timescale 1ns/1ps
module tb_debug_step_ctrl;
    import dbg_defs::*;

    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int STEP_LEN = 4;
    localparam int MAX_CYC  = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [7:0]       cmd = 8'h00;
    logic             halt = 1'b0;
    logic             dump_done = 1'b0;
    logic             cmd_ready, pipe_en, dump_req, halted, timeout;
    logic [CNT_W-1:0] cycle_cnt;

    debug_step_ctrl #(
        .CNT_W      (CNT_W),
        .STEP_LEN   (STEP_LEN),
        .MAX_CYCLES (32'(MAX_CYC))
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .o_cmd_ready (cmd_ready),
        .i_halt      (halt),
        .o_pipe_en   (pipe_en),
        .o_dump_req  (dump_req),
        .i_dump_done (dump_done),
        .o_halted    (halted),
        .o_timeout   (timeout),
        .o_cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // One expected dump: length of the enable burst before it, counter value, where it lands, watchdog flag.
    typedef struct {
        int en_len;
        int cnt;
        bit halted;
        bit tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   dumps_done = 0;
    int   halt_at = 0;
    bit   hold_dump = 1'b0;
    bit   tmo_sticky = 1'b0;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_dump(input int len, input int cnt_v, input bit h);
        exp_t e;
        e.en_len = len;
        e.cnt    = cnt_v;
        e.halted = h;
        e.tmo    = tmo_sticky;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pipe_en"}, int'(pipe_en), 0);
        chk({tag, "_dump_req"}, int'(dump_req), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 0);
        chk({tag, "_cycle_cnt"}, int'(cycle_cnt), 0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accepted", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_all(input string name);
        int n = 0;
        while (dumps_done != pushed && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, dumps_done, pushed);
    endtask

    task automatic wait_pipe_idle();
        int n = 0;
        while (pipe_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pipe_burst_ends", int'(pipe_en), 0);
    endtask

    // Pipeline model: raises i_halt in the halt_at-th cycle of each enable burst.
    task automatic pipe_loop();
        int burst = 0;
        forever begin
            @(negedge clk);
            if (rst || !pipe_en) begin
                burst = 0;
                halt  = 1'b0;
            end else begin
                burst++;
                halt = (burst == halt_at);
            end
        end
    endtask

    // TX sequencer model: answers each dump request after a random delay.
    task automatic dump_loop();
        forever begin
            @(negedge clk);
            if (dump_req && !rst && !hold_dump) begin
                int d;
                d = $urandom_range(0, 4);
                repeat (d) @(negedge clk);
                if (!rst && !hold_dump) begin
                    dump_done = 1'b1;
                    @(negedge clk);
                    dump_done = 1'b0;
                end
            end
        end
    endtask

    task automatic mon_loop();
        int   en_run = 0;
        int   last_burst = 0;
        bit   prev_dump = 1'b0;
        bit   pend = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_run    = 0;
                prev_dump = 1'b0;
                pend      = 1'b0;
            end else begin
                if (pipe_en) begin
                    en_run++;
                end else if (en_run != 0) begin
                    last_burst = en_run;
                    en_run     = 0;
                end
                chk("pipe_en_exclusive", int'(pipe_en && (dump_req || halted)), 0);
                if (dump_req) chk("ready_low_in_dump", int'(cmd_ready), 0);
                if (dump_req && !prev_dump) begin
                    chk("dump_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        cur  = sb.pop_front();
                        pend = 1'b1;
                        chk("dump_en_len", last_burst, cur.en_len);
                        chk("dump_cycle_cnt", int'(cycle_cnt), cur.cnt);
                        chk("dump_timeout", int'(timeout), int'(cur.tmo));
                    end
                end
                if (!dump_req && prev_dump && pend) begin
                    chk("post_dump_halted", int'(halted), int'(cur.halted));
                    chk("post_dump_ready", int'(cmd_ready), 1);
                    pend = 1'b0;
                    dumps_done++;
                end
                prev_dump = dump_req;
            end
        end
    endtask

    task automatic run_session(input int h);
        int len;
        bit to;
`ifdef DBG_TIMEOUT_EN
        to = (h == 0) || (h > MAX_CYC);
`else
        to = 1'b0;
`endif
        len = to ? MAX_CYC : h;
        if (to) tmo_sticky = 1'b1;
        expect_dump(len, sat(len), 1'b1);
        halt_at = h;
        send_cmd(CMD_RUN);
        wait_all("run_dump_done");
        send_cmd(CMD_RUN);
        repeat (3) @(negedge clk);
        chk("halted_ignores_run", int'(pipe_en), 0);
        chk("halted_holds", int'(halted), 1);
        chk("halted_cnt_frozen", int'(cycle_cnt), sat(len));
        send_cmd(CMD_END_DEBUG);
        chk("run_back_idle", int'(halted), 0);
    endtask

    task automatic debug_session(input int nsteps);
        int acc = 0;
        int k = 0;
        send_cmd(CMD_DEBUG);
        chk("debug_cnt_cleared", int'(cycle_cnt), 0);
        for (int i = 0; i < nsteps; i++) begin
            wait_pipe_idle();
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, STEP_LEN) : 0;
            acc += (k != 0) ? k : STEP_LEN;
            expect_dump((k != 0) ? k : STEP_LEN, sat(acc), k != 0);
            halt_at = k;
            send_cmd(CMD_NEXT);
            if (k != 0) break;
        end
        wait_all("step_dumps_done");
        if (k != 0) begin
            send_cmd(CMD_NEXT);
            repeat (3) @(negedge clk);
            chk("halted_ignores_next", int'(pipe_en), 0);
            chk("step_halted", int'(halted), 1);
        end else begin
            send_cmd(8'h55);
            repeat (2) @(negedge clk);
            chk("unknown_cmd_ignored", int'(pipe_en), 0);
        end
        chk("debug_cycle_cnt", int'(cycle_cnt), sat(acc));
        send_cmd(CMD_END_DEBUG);
        chk("debug_back_idle", int'(halted), 0);
        chk("debug_idle_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            mon_loop();
            pipe_loop();
            dump_loop();
        join_none

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(cmd_ready), 1);

        send_cmd(8'h3C);
        repeat (2) @(negedge clk);
        chk("idle_unknown_ignored", int'(pipe_en), 0);

        run_session(10);
        debug_session(3);

`ifdef DBG_TIMEOUT_EN
        run_session(0);
`endif

        hold_dump = 1'b1;
        expect_dump(3, 3, 1'b1);
        halt_at = 3;
        send_cmd(CMD_RUN);
        n = 0;
        while (!dump_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dump_before_reset", int'(dump_req), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("reset_in_dump");
        pushed--;
        tmo_sticky = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        hold_dump = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_ready", int'(cmd_ready), 1);
        chk("idle_after_reset_dump", int'(dump_req), 0);

        for (int s = 0; s < 24; s++) begin
            if ($urandom_range(0, 1) == 0) begin
`ifdef DBG_TIMEOUT_EN
                run_session($urandom_range(0, 40));
`else
                run_session($urandom_range(1, 40));
`endif
            end else begin
                debug_session($urandom_range(1, 5));
            end
        end

`ifndef DBG_TIMEOUT_EN
        chk("timeout_tied_low", int'(timeout), 0);
`endif
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
